ace_controller: RTL and testbench
=================================

# ace_controller

Cache-side ACE master sitting between the cache controller and the coherent interconnect. It accepts line-granular read, writeback and invalidate requests over the `read_req`/`write_req`/`invalid_req` → `ace_ready` handshake. Each request is turned into a ReadShared, WriteBack or CleanUnique transaction on simplified AR/R/AW/W/B channels with RACK/WACK acknowledge. Fill data and the error status are returned together with a one-cycle `ace_ready` completion pulse.

## Interface
- ADDR_WIDTH, 32, request/bus address width
- DATA_WIDTH, 32, bus beat width (bits)
- LINE_WORDS, 4, beats per cache line (power of two, ≥2); LINE_BITS = DATA_WIDTH*LINE_WORDS
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- read_req / write_req / invalid_req  in  1 each  request strobes from the cache controller
- req_addr  in  ADDR_WIDTH  line address; wb_data  in  LINE_BITS  dirty line (word 0 = bits [DATA_WIDTH-1:0])
- ace_ready  out  1  one-cycle completion pulse; ace_error  out  1  transaction error status
- fill_data  out  LINE_BITS  line returned by a read
- resp_shared / resp_dirty  out  1 each  fill response state (macro-dependent)
- ar_valid out 1, ar_ready in 1, ar_addr out ADDR_WIDTH, ar_snoop out 4, ar_len out 8
- r_valid in 1, r_ready out 1, r_data in DATA_WIDTH, r_resp in 4, r_last in 1
- aw_valid out 1, aw_ready in 1, aw_addr out ADDR_WIDTH, aw_snoop out 3, aw_len out 8
- w_valid out 1, w_ready in 1, w_data out DATA_WIDTH, w_last out 1
- b_valid in 1, b_ready out 1, b_resp in 2
- rack / wack  out  1 each  ACE read/write acknowledge

## Operation
- States: IDLE, AR_REQ, R_DATA, AW_REQ, W_DATA, B_RESP, ACK.
- IDLE: sample requests with priority write_req > read_req > invalid_req.
  - On acceptance, latch the opcode and the line-aligned address (low log2(LINE_BITS/8) bits zeroed). On a write, also latch wb_data. Clear ace_error.
  - Write goes to AW_REQ; read or invalidate goes to AR_REQ.
  - Strobes seen outside IDLE are ignored. A single-cycle strobe is enough: invalidate is issued as a one-cycle pulse.
- AR_REQ:
  - Hold ar_valid with stable fields until ar_ready, then go to R_DATA.
  - Read: ar_snoop=4'b0001 (ReadShared), ar_len=LINE_WORDS-1.
  - Invalidate: ar_snoop=4'b1011 (CleanUnique), ar_len=0.
- R_DATA:
  - r_ready=1. Each r_valid beat of a read writes r_data into fill word beat_cnt; invalidate data is discarded.
  - The beat counter saturates at LINE_WORDS-1, and extra beats are dropped.
  - Any r_resp[1:0]≠0 sets ace_error. An r_last that does not arrive on the expected beat also sets ace_error.
  - r_last goes to ACK.
- AW_REQ: aw_valid, aw_snoop=3'b011 (WriteBack), aw_len=LINE_WORDS-1; advance on aw_ready.
- W_DATA:
  - w_valid=1, w_data=latched word[beat_cnt]; advance on w_ready.
  - w_last is asserted on beat LINE_WORDS-1; its handshake goes to B_RESP.
- B_RESP: b_ready=1; on b_valid, b_resp≠0 sets ace_error, then go to ACK.
- ACK: ace_ready=1 plus rack (read/invalidate) or wack (write) for exactly one cycle, then IDLE.
- fill_data holds its value until the next read's first beat. ace_error holds until the next acceptance.

## Timing
- Reset (sync, overrides everything, including mid-transaction abandonment):
  - State IDLE, beat counter 0.
  - Forced to 0: all valids/readies, rack, wack, ace_ready, ace_error, fill_data, resp_*, ar_*/aw_* fields, w_data, w_last.
- Zero-wait read: request at cycle 0, AR at cycle 1, beats at cycles 2–5, ace_ready at cycle 6 with fill_data valid.
- Zero-wait write: AW at 1, W at 2–5, B at 6, ace_ready at 7.
- Zero-wait invalidate: ace_ready at cycle 3.
- Stalls (ready/valid low) extend the corresponding state one cycle at a time. Outputs never drop while waiting for a handshake.
- ace_ready is registered state, not combinational with channel inputs.
- The cycle after ACK, the block is in IDLE and can accept a request held since the ace_ready cycle, e.g. a read issued right after a writeback.

## Configuration
- ACE_RESP_STATE_EN defined: on the first read beat, resp_shared=r_resp[3] and resp_dirty=r_resp[2] are latched. They are held like fill_data, so the cache can choose the UC/SC/SD fill state.
- Undefined: resp_shared and resp_dirty are tied to 0 and no latch is built.

## Structure
- Package ace_pkg: state enum, ACE snoop constants (READ_SHARED, CLEAN_UNIQUE, WRITE_BACK), OKAY response constant.
- Sub-module ace_line_buffer: line register with beat counter, word write-in and word select-out, shared by the R and W paths.

## Test plan
- Read to 0x1004, ar_ready=1, four r_valid beats 0xA0..0xA3 with r_last on the 4th:
  - ar_addr=0x1000, ar_len=3, ar_snoop=0001.
  - ace_ready and rack at cycle 6, fill_data=0xA3A2A1A0.
- Writeback of 0xDDCCBBAA at 0x2000:
  - w_data=AA,BB,CC,DD, w_last on DD.
  - With w_ready low for 2 cycles at beat 1, ace_ready and wack arrive 2 cycles late.
- invalid_req one-cycle pulse: ar_snoop=1011, ar_len=0; one R beat gives ace_ready with fill_data unchanged.
- Error cases:
  - r_resp=2'b10 on beat 2 gives ace_error=1 at ace_ready.
  - r_last on beat 1 gives early ACK with ace_error=1.
- write_req and read_req asserted together in IDLE: the AW path is taken and read_req is ignored until IDLE.
- reset asserted during W_DATA: next cycle all outputs are 0 and the state is IDLE; a new read completes normally.

Source files
------------

// File: rtl/ace_pkg.sv
// Shared types and ACE encodings for the cache-side ACE master.
package ace_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArReq,
        StRData,
        StAwReq,
        StWData,
        StBResp,
        StAck
    } ace_state_e;

    typedef enum logic [1:0] {
        OpRead,
        OpWrite,
        OpInval
    } ace_op_e;

    localparam logic [3:0] READ_SHARED  = 4'b0001;
    localparam logic [3:0] CLEAN_UNIQUE = 4'b1011;
    localparam logic [2:0] WRITE_BACK   = 3'b011;
    localparam logic [1:0] OKAY         = 2'b00;

endpackage

// File: rtl/ace_line_buffer.sv
// Line register with a saturating beat counter; R beats write words in,
// the W path reads the selected word of an external line out.
module ace_line_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned LineBits = DATA_WIDTH * LINE_WORDS,
    localparam int unsigned CntW     = $clog2(LINE_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_beat,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [LineBits-1:0]   i_sel_line,
    output logic [LineBits-1:0]   o_line,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic [CntW-1:0]       o_cnt,
    output logic                  o_full
);

    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_WORDS - 1);

    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] r_line;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] w_sel;
    logic [CntW-1:0]                       r_cnt;
    logic                                  r_full;

    // r_full marks that the last word was consumed; further beats are dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_line <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_wr_en && !r_full) begin
                r_line[r_cnt] <= i_wr_data;
            end
            if (i_clear) begin
                r_cnt  <= '0;
                r_full <= 1'b0;
            end else if (i_beat && !r_full) begin
                if (r_cnt == LastBeat) begin
                    r_full <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign w_sel  = i_sel_line;
    assign o_word = w_sel[r_cnt];
    assign o_line = r_line;
    assign o_cnt  = r_cnt;
    assign o_full = r_full;

endmodule

// File: rtl/ace_controller.sv
// Cache-side ACE master: ReadShared / WriteBack / CleanUnique over AR/R/AW/W/B.
// Optional macro ACE_RESP_STATE_EN latches the fill response state bits.
module ace_controller
    import ace_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned LINE_BITS = DATA_WIDTH * LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_req,
    input  logic                  write_req,
    input  logic                  invalid_req,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_BITS-1:0]  wb_data,
    output logic                  ace_ready,
    output logic                  ace_error,
    output logic [LINE_BITS-1:0]  fill_data,
    output logic                  resp_shared,
    output logic                  resp_dirty,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [3:0]            ar_snoop,
    output logic [7:0]            ar_len,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [3:0]            r_resp,
    input  logic                  r_last,
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [ADDR_WIDTH-1:0] aw_addr,
    output logic [2:0]            aw_snoop,
    output logic [7:0]            aw_len,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [1:0]            b_resp,
    output logic                  rack,
    output logic                  wack
);

    localparam int unsigned     OffBits  = $clog2(LINE_BITS / 8);
    localparam int unsigned     CntW     = $clog2(LINE_WORDS);
    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_WORDS - 1);
    localparam logic [7:0]      BurstLen = 8'(LINE_WORDS - 1);

    ace_state_e            r_state;
    ace_op_e               r_op;
    logic [LINE_BITS-1:0]  r_wb_line;
    logic                  r_ar_valid, r_r_ready, r_aw_valid, r_w_valid, r_b_ready;
    logic [ADDR_WIDTH-1:0] r_ar_addr, r_aw_addr;
    logic [3:0]            r_ar_snoop;
    logic [2:0]            r_aw_snoop;
    logic [7:0]            r_ar_len, r_aw_len;
    logic                  r_ace_ready, r_ace_error, r_rack, r_wack;

    logic [ADDR_WIDTH-1:0] w_line_addr;
    logic                  w_accept, w_rbeat, w_whs, w_fill_en, w_exp_last, w_r_err;
    logic [DATA_WIDTH-1:0] w_word;
    logic [CntW-1:0]       w_cnt;
    logic                  w_full;
    logic                  w_unused_bits;

    assign w_line_addr = {req_addr[ADDR_WIDTH-1:OffBits], {OffBits{1'b0}}};
    assign w_accept    = (r_state == StIdle) && (write_req || read_req || invalid_req);
    assign w_rbeat     = (r_state == StRData) && r_valid;
    assign w_whs       = (r_state == StWData) && w_ready;
    assign w_fill_en   = w_rbeat && (r_op == OpRead);

    // r_last must coincide with the final beat of the burst the AR asked for.
    assign w_exp_last = !w_full && ((r_op == OpInval) ? (w_cnt == '0) : (w_cnt == LastBeat));
    assign w_r_err    = (r_resp[1:0] != OKAY) || (r_last != w_exp_last);

    ace_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buffer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_clear    (w_accept),
        .i_beat     (w_rbeat || w_whs),
        .i_wr_en    (w_fill_en),
        .i_wr_data  (r_data),
        .i_sel_line (r_wb_line),
        .o_line     (fill_data),
        .o_word     (w_word),
        .o_cnt      (w_cnt),
        .o_full     (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_op        <= OpRead;
            r_wb_line   <= '0;
            r_ar_valid  <= 1'b0;
            r_ar_addr   <= '0;
            r_ar_snoop  <= '0;
            r_ar_len    <= '0;
            r_r_ready   <= 1'b0;
            r_aw_valid  <= 1'b0;
            r_aw_addr   <= '0;
            r_aw_snoop  <= '0;
            r_aw_len    <= '0;
            r_w_valid   <= 1'b0;
            r_b_ready   <= 1'b0;
            r_ace_ready <= 1'b0;
            r_ace_error <= 1'b0;
            r_rack      <= 1'b0;
            r_wack      <= 1'b0;
        end else begin
            r_ace_ready <= 1'b0;
            r_rack      <= 1'b0;
            r_wack      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (write_req) begin
                        r_op        <= OpWrite;
                        r_aw_addr   <= w_line_addr;
                        r_aw_snoop  <= WRITE_BACK;
                        r_aw_len    <= BurstLen;
                        r_aw_valid  <= 1'b1;
                        r_wb_line   <= wb_data;
                        r_ace_error <= 1'b0;
                        r_state     <= StAwReq;
                    end else if (read_req || invalid_req) begin
                        r_op        <= read_req ? OpRead : OpInval;
                        r_ar_addr   <= w_line_addr;
                        r_ar_snoop  <= read_req ? READ_SHARED : CLEAN_UNIQUE;
                        r_ar_len    <= read_req ? BurstLen : 8'd0;
                        r_ar_valid  <= 1'b1;
                        r_ace_error <= 1'b0;
                        r_state     <= StArReq;
                    end
                end
                StArReq: begin
                    if (ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= StRData;
                    end
                end
                StRData: begin
                    if (r_valid) begin
                        if (w_r_err) begin
                            r_ace_error <= 1'b1;
                        end
                        if (r_last) begin
                            r_r_ready   <= 1'b0;
                            r_ace_ready <= 1'b1;
                            r_rack      <= 1'b1;
                            r_state     <= StAck;
                        end
                    end
                end
                StAwReq: begin
                    if (aw_ready) begin
                        r_aw_valid <= 1'b0;
                        r_w_valid  <= 1'b1;
                        r_state    <= StWData;
                    end
                end
                StWData: begin
                    if (w_ready && (w_cnt == LastBeat)) begin
                        r_w_valid <= 1'b0;
                        r_b_ready <= 1'b1;
                        r_state   <= StBResp;
                    end
                end
                StBResp: begin
                    if (b_valid) begin
                        if (b_resp != OKAY) begin
                            r_ace_error <= 1'b1;
                        end
                        r_b_ready   <= 1'b0;
                        r_ace_ready <= 1'b1;
                        r_wack      <= 1'b1;
                        r_state     <= StAck;
                    end
                end
                StAck:   r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef ACE_RESP_STATE_EN
    logic r_resp_shared, r_resp_dirty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_shared <= 1'b0;
            r_resp_dirty  <= 1'b0;
        end else if (w_fill_en && !w_full && (w_cnt == '0)) begin
            r_resp_shared <= r_resp[3];
            r_resp_dirty  <= r_resp[2];
        end
    end

    assign resp_shared   = r_resp_shared;
    assign resp_dirty    = r_resp_dirty;
    assign w_unused_bits = ^req_addr[OffBits-1:0];
`else
    assign resp_shared   = 1'b0;
    assign resp_dirty    = 1'b0;
    assign w_unused_bits = ^{req_addr[OffBits-1:0], r_resp[3:2]};
`endif

    assign ar_valid  = r_ar_valid;
    assign ar_addr   = r_ar_addr;
    assign ar_snoop  = r_ar_snoop;
    assign ar_len    = r_ar_len;
    assign r_ready   = r_r_ready;
    assign aw_valid  = r_aw_valid;
    assign aw_addr   = r_aw_addr;
    assign aw_snoop  = r_aw_snoop;
    assign aw_len    = r_aw_len;
    assign w_valid   = r_w_valid;
    assign w_data    = r_w_valid ? w_word : '0;
    assign w_last    = r_w_valid && (w_cnt == LastBeat);
    assign b_ready   = r_b_ready;
    assign ace_ready = r_ace_ready;
    assign ace_error = r_ace_error;
    assign rack      = r_rack;
    assign wack      = r_wack;

endmodule

// File: tb/tb_ace_controller.sv
// Directed bench for ace_controller: read, stalled writeback, invalidate,
// error responses, write/read priority and reset during W_DATA.
module tb_ace_controller;

    logic         clk;
    logic         reset;
    logic         read_req, write_req, invalid_req;
    logic [31:0]  req_addr;
    logic [127:0] wb_data;
    logic         ace_ready, ace_error;
    logic [127:0] fill_data;
    logic         resp_shared, resp_dirty;
    logic         ar_valid, ar_ready;
    logic [31:0]  ar_addr;
    logic [3:0]   ar_snoop;
    logic [7:0]   ar_len;
    logic         r_valid, r_ready;
    logic [31:0]  r_data;
    logic [3:0]   r_resp;
    logic         r_last;
    logic         aw_valid, aw_ready;
    logic [31:0]  aw_addr;
    logic [2:0]   aw_snoop;
    logic [7:0]   aw_len;
    logic         w_valid, w_ready;
    logic [31:0]  w_data;
    logic         w_last;
    logic         b_valid, b_ready;
    logic [1:0]   b_resp;
    logic         rack, wack;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

`ifdef ACE_RESP_STATE_EN
    localparam logic ExpShared = 1'b1;
    localparam logic ExpDirty  = 1'b1;
`else
    localparam logic ExpShared = 1'b0;
    localparam logic ExpDirty  = 1'b0;
`endif

    ace_controller #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LINE_WORDS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .read_req    (read_req),
        .write_req   (write_req),
        .invalid_req (invalid_req),
        .req_addr    (req_addr),
        .wb_data     (wb_data),
        .ace_ready   (ace_ready),
        .ace_error   (ace_error),
        .fill_data   (fill_data),
        .resp_shared (resp_shared),
        .resp_dirty  (resp_dirty),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .ar_addr     (ar_addr),
        .ar_snoop    (ar_snoop),
        .ar_len      (ar_len),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .r_last      (r_last),
        .aw_valid    (aw_valid),
        .aw_ready    (aw_ready),
        .aw_addr     (aw_addr),
        .aw_snoop    (aw_snoop),
        .aw_len      (aw_len),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .w_last      (w_last),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_resp      (b_resp),
        .rack        (rack),
        .wack        (wack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] data, input logic [3:0] resp, input logic last);
        r_valid = 1'b1;
        r_data  = data;
        r_resp  = resp;
        r_last  = last;
    endtask

    initial begin
        reset = 1'b1;  read_req = 1'b0;  write_req = 1'b0;  invalid_req = 1'b0;
        req_addr = '0; wb_data = '0;
        ar_ready = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
        r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0;
        b_valid = 1'b0; b_resp = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ace_ready", ace_ready, 0);
        chk("rst_ace_error", ace_error, 0);
        chk("rst_fill", fill_data, 0);
        chk("rst_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready, rack, wack}, 0);

        // Zero-wait read of 0x1004
        read_req = 1'b1; req_addr = 32'h1004;
        tick();
        read_req = 1'b0;
        chk("rd_ar_valid", ar_valid, 1);
        chk("rd_ar_addr", ar_addr, 32'h1000);
        chk("rd_ar_len", ar_len, 3);
        chk("rd_ar_snoop", ar_snoop, 4'b0001);
        tick();
        chk("rd_r_ready", r_ready, 1);
        chk("rd_ar_drop", ar_valid, 0);
        beat(32'hA0, 4'b1100, 1'b0);
        tick(); beat(32'hA1, 4'b0000, 1'b0);
        tick(); beat(32'hA2, 4'b0000, 1'b0);
        tick(); beat(32'hA3, 4'b0000, 1'b1);
        chk("rd_not_early", ace_ready, 0);
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        chk("rd_ace_ready", ace_ready, 1);
        chk("rd_rack_wack", {rack, wack}, 2'b10);
        chk("rd_fill", fill_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("rd_error", ace_error, 0);
        chk("rd_resp_state", {resp_shared, resp_dirty}, {ExpShared, ExpDirty});
        tick();
        chk("rd_pulse_end", {ace_ready, rack}, 0);

        // Writeback with read_req held alongside; w_ready stalls at beat 1
        write_req = 1'b1; read_req = 1'b1; req_addr = 32'h2000;
        wb_data = 128'h000000DD_000000CC_000000BB_000000AA;
        tick();
        write_req = 1'b0;
        chk("wr_aw_valid", aw_valid, 1);
        chk("wr_aw_fields", {aw_addr, aw_snoop, aw_len}, {32'h2000, 3'b011, 8'd3});
        chk("wr_no_ar", ar_valid, 0);
        tick();
        chk("wr_w0", {w_valid, w_data, w_last}, {1'b1, 32'hAA, 1'b0});
        tick();
        chk("wr_w1", w_data, 32'hBB);
        w_ready = 1'b0;
        tick();
        chk("wr_w1_stall", {w_valid, w_data}, {1'b1, 32'hBB});
        tick();
        chk("wr_w1_stall2", {w_valid, w_data}, {1'b1, 32'hBB});
        w_ready = 1'b1;
        tick();
        chk("wr_w2", w_data, 32'hCC);
        tick();
        chk("wr_w3", {w_data, w_last}, {32'hDD, 1'b1});
        tick();
        chk("wr_b_ready", {b_ready, w_valid}, 2'b10);
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("wr_ace_ready", ace_ready, 1);
        chk("wr_rack_wack", {rack, wack}, 2'b01);
        chk("wr_error", ace_error, 0);
        tick();
        chk("wr_idle", {ace_ready, ar_valid}, 0);
        tick();
        read_req = 1'b0;
        chk("rd2_ar", {ar_valid, ar_addr, ar_snoop}, {1'b1, 32'h2000, 4'b0001});

        // Held read completes; beat 2 carries an error response
        tick(); beat(32'hB0, 4'b0000, 1'b0);
        tick(); beat(32'hB1, 4'b0000, 1'b0);
        tick(); beat(32'hB2, 4'b0010, 1'b0);
        tick(); beat(32'hB3, 4'b0000, 1'b1);
        tick();
        r_valid = 1'b0; r_last = 1'b0; r_resp = '0;
        chk("rerr_ace_ready", ace_ready, 1);
        chk("rerr_error", ace_error, 1);
        chk("rerr_fill", fill_data, 128'h000000B3_000000B2_000000B1_000000B0);
        tick();
        chk("rerr_error_hold", {ace_ready, ace_error}, 2'b01);

        // Invalidate pulse
        invalid_req = 1'b1; req_addr = 32'h3008;
        tick();
        invalid_req = 1'b0;
        chk("inv_ar", {ar_valid, ar_addr, ar_snoop, ar_len}, {1'b1, 32'h3000, 4'b1011, 8'd0});
        tick();
        chk("inv_err_clr", ace_error, 0);
        beat(32'hDEAD, 4'b0000, 1'b1);
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        chk("inv_ack", {ace_ready, rack, wack}, 3'b110);
        chk("inv_fill_keep", fill_data, 128'h000000B3_000000B2_000000B1_000000B0);
        chk("inv_error", ace_error, 0);

        // Early r_last on the second beat
        tick();
        read_req = 1'b1; req_addr = 32'h4000;
        tick();
        read_req = 1'b0;
        tick(); beat(32'hC0, 4'b0000, 1'b0);
        tick(); beat(32'hC1, 4'b0000, 1'b1);
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        chk("early_ack", {ace_ready, rack}, 2'b11);
        chk("early_error", ace_error, 1);
        chk("early_fill", fill_data, 128'h000000B3_000000B2_000000C1_000000C0);

        // Reset during W_DATA, then a clean read
        tick();
        write_req = 1'b1; req_addr = 32'h5000;
        wb_data = 128'h44444444_33333333_22222222_11111111;
        tick();
        write_req = 1'b0;
        tick();
        chk("rstw_w0", {w_valid, w_data}, {1'b1, 32'h11111111});
        tick();
        chk("rstw_w1", {w_valid, w_data}, {1'b1, 32'h22222222});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_w_zero", {w_valid, w_data, w_last, b_ready}, 0);
        chk("rstw_aw_zero", {aw_valid, aw_addr, aw_snoop, aw_len}, 0);
        chk("rstw_misc_zero", {ace_ready, ace_error, rack, wack, r_ready, ar_valid}, 0);
        chk("rstw_fill_zero", fill_data, 0);
        read_req = 1'b1; req_addr = 32'h6000;
        tick();
        read_req = 1'b0;
        chk("rstw_rd_ar", {ar_valid, ar_addr}, {1'b1, 32'h6000});
        tick(); beat(32'h61, 4'b0000, 1'b0);
        tick(); beat(32'h62, 4'b0000, 1'b0);
        tick(); beat(32'h63, 4'b0000, 1'b0);
        tick(); beat(32'h64, 4'b0000, 1'b1);
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        chk("rstw_rd_ack", {ace_ready, rack, ace_error}, 3'b110);
        chk("rstw_rd_fill", fill_data, 128'h00000064_00000063_00000062_00000061);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
